// File: rtl/rr_mux4_if.sv
// Bundle of the four producer channels and the single merged consumer channel
// that rr_mux4 connects together.
interface rr_mux4_if #(
    parameter int DATA_W = 8
);
    logic [3:0]          in_valid;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          in_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_sel;
    logic                out_ready;

    // Merger side: it takes the producer channels and drives the merged output.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    // Environment side: producers and the consumer.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_mux4.sv
// rr_mux4: merges four valid/ready producers into one registered output stage.
// A round-robin pointer picks the producer, and each output word is tagged
// with the index of the channel it came from.
module rr_mux4 #(
    parameter int DATA_W = 8
) (
    input  logic     clk,
    input  logic     rst,
    rr_mux4_if.slave bus
);
    logic [1:0]        r_ptr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [1:0]        r_out_sel;

    logic              w_load;
    logic              w_grant;
    logic [1:0]        w_g;
    logic [3:0]        w_in_ready;
    logic [DATA_W-1:0] w_data;

    // The output register can accept a word when it is empty or being drained.
    assign w_load = ~r_out_valid | bus.out_ready;

    // Round-robin search starting at r_ptr. The loop runs from the farthest
    // offset to the nearest, so the nearest valid channel is the one that wins.
    always_comb begin
        logic [1:0] idx;
        idx     = '0;
        w_grant = 1'b0;
        w_g     = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = r_ptr + 2'(k);
            if (bus.in_valid[idx]) begin
                w_grant = 1'b1;
                w_g     = idx;
            end
        end
    end

    assign w_data = bus.in_data[w_g*DATA_W +: DATA_W];

    // Drive a one-hot ready only to the granted channel, and only when the
    // output register can take the word. Ready is forced low during reset.
    assign w_in_ready = (w_load && w_grant && !rst) ? (4'b0001 << w_g) : 4'b0000;

    // Output register and priority pointer. A grant loads a new word. A free
    // slot with no request empties the register. Under backpressure the
    // register holds its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= 2'b00;
            r_ptr       <= 2'b00;
        end else if (w_load) begin
            if (w_grant) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data;
                r_out_sel   <= w_g;
                r_ptr       <= w_g + 2'd1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
endmodule

// File: tb/tb_rr_mux4.sv
// Self-checking bench for rr_mux4. Producer queues supply the channels, and the
// expected output words are queued in arbitration order at the point the
// stimulus is loaded.
module tb_rr_mux4;
    localparam int DATA_W = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    rr_mux4_if #(.DATA_W(DATA_W)) bus ();

    rr_mux4 #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-channel producer word lists. chn is the number of words queued on a
    // channel, and chh is the index of the next word still to be sent.
    logic [DATA_W-1:0] chw [4][16];
    int                chn [4];
    int                chh [4];
    logic [9:0]        sbq [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic enq(input int ch, input logic [DATA_W-1:0] d);
        chw[ch][chn[ch]] = d;
        chn[ch]++;
    endtask

    task automatic expect_word(input logic [1:0] sel, input logic [DATA_W-1:0] d);
        sbq.push_back({sel, d});
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid[i] = (chh[i] < chn[i]);
            bus.in_data[i*DATA_W +: DATA_W] = (chh[i] < chn[i]) ? chw[i][chh[i]] : '0;
        end
    endtask

    // One clock cycle. At the negedge the bench samples ready, checks it, and
    // records the transfers that the coming posedge commits. The producers
    // update just after the posedge.
    task automatic step();
        logic [3:0] rdy;
        logic [9:0] e;
        @(negedge clk);
        rdy = bus.in_ready;
        chk("rdy_onehot", 32'($countones(rdy) <= 1), 32'd1);
        for (int i = 0; i < 4; i++)
            if (bus.in_valid[i] && rdy[i]) chh[i]++;
        if (bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) chk("sb_underflow", {22'd0, bus.out_sel, bus.out_data}, 32'h3ff);
            else begin
                e = sbq.pop_front();
                chk("out_word", {22'd0, bus.out_sel, bus.out_data}, {22'd0, e});
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    function automatic bit pending();
        bit p;
        p = (sbq.size() != 0);
        for (int i = 0; i < 4; i++) if (chh[i] < chn[i]) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (pending() && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_drain_timeout"}, 32'(pending()), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 4; i++) begin chn[i] = 0; chh[i] = 0; end
        rst           = 1'b1;
        bus.in_valid  = 4'hF;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #3;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_data",  32'(bus.out_data), 32'd0);
        chk("rst_sel",   32'(bus.out_sel), 32'd0);
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset mid-stream. A word sits in the output register and is stalled,
        // then reset is asserted asynchronously.
        enq(0, 8'h5A);
        drive();
        step();
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        enq(0, 8'hA5);
        drive();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_data",  32'(bus.out_data), 32'd0);
        chk("mid_rst_sel",   32'(bus.out_sel), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        expect_word(2'd0, 8'hA5);
        drain("rst_a5");

        // Single channel: only channel 2 is valid. After this ptr = 3.
        enq(2, 8'h3C);
        expect_word(2'd2, 8'h3C);
        drive();
        #1;
        chk("ch2_ready", 32'(bus.in_ready), 32'h4);
        drain("ch2");

        // Wrap: with ptr = 3, channel 3 goes before channel 0. After this ptr = 1.
        enq(3, 8'hC3);
        enq(0, 8'hC0);
        expect_word(2'd3, 8'hC3);
        expect_word(2'd0, 8'hC0);
        drive();
        drain("wrap");

        // A grant to channel 3 alone moves ptr from 1 to 0.
        enq(3, 8'h77);
        expect_word(2'd3, 8'h77);
        drive();
        drain("ch3_solo");

        // Round robin: all four channels stay valid and grants rotate 0,1,2,3 twice.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) begin
                enq(i, 8'(8'h10 + i));
                expect_word(2'(i), 8'(8'h10 + i));
            end
        drive();
        drain("rr");

        // Backpressure. Channel 1 loads first, then the output stalls for
        // three cycles while channel 3 waits.
        bus.out_ready = 1'b0;
        enq(1, 8'hB1);
        enq(3, 8'hB3);
        expect_word(2'd1, 8'hB1);
        expect_word(2'd3, 8'hB3);
        drive();
        step();
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_data",  32'(bus.out_data), 32'hB1);
            chk("bp_sel",   32'(bus.out_sel), 32'd1);
            chk("bp_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'h8);
        step();
        chk("no_bubble_valid", 32'(bus.out_valid), 32'd1);
        chk("no_bubble_data",  32'(bus.out_data), 32'hB3);
        drain("bp");

        // Idle: the register empties after the consume edge. ptr is still 0,
        // so channel 0 goes before channel 1.
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("idle_valid2", 32'(bus.out_valid), 32'd0);
        enq(1, 8'hD1);
        enq(0, 8'hD0);
        expect_word(2'd0, 8'hD0);
        expect_word(2'd1, 8'hD1);
        drive();
        drain("ptr_hold");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
